button_reader: RTL and testbench

Input-side counterpart to the RGB LED driver: samples one active-low board pushbutton, synchronises and debounces it, and turns it into a clean level plus single-cycle press, release, click and long-press events. Sits between the top-level button pin and any logic that consumes user input, such as colour/mode selection feeding the LED outputs.

---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/button_reader.sv | 123 ++++++++++++
 tb/tb_button_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton reader and
// related board-input logic.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ      = 12000000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned LONG_MS     = 1000;

  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a configurable reset value, for asynchronous
// board inputs.
module sync_2ff #(
  parameter int unsigned        WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_reader.sv
// Debounced active-low pushbutton reader: clean level plus one-cycle press,
// release, click and long-press strobes.
//
// state      | meaning
// IDLE       | button accepted as released
// PRESS_DB   | counting stable low samples before accepting a press
// HELD       | button accepted as down, hold time accumulating
// RELEASE_DB | counting stable high samples before accepting a release
module button_reader
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS,
  parameter int unsigned LONG_CYCLES     = CYCLES_PER_MS * LONG_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic btn_s;

  btn_state_e        state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_done_q;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .d_i     (btn_n),
    .q_o     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_done_q   <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!btn_s) begin
            state_q  <= PRESS_DB;
            db_cnt_q <= DB_W'(1);
          end
        end

        PRESS_DB: begin
          if (btn_s) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_MAX) begin
            state_q     <= HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end

        HELD: begin
          // A release sample takes priority over the hold count reaching its limit.
          if (btn_s) begin
            state_q  <= RELEASE_DB;
            db_cnt_q <= DB_W'(1);
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            if ((hold_cnt_q == HOLD_MAX - HOLD_W'(1)) && !long_done_q) begin
              long_pulse  <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
        end

        RELEASE_DB: begin
          // hold_cnt_q is left untouched so a bounce resumes the hold where it stopped.
          if (!btn_s) begin
            state_q <= HELD;
          end else if (db_cnt_q == DB_MAX) begin
            state_q       <= IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
            click_pulse   <= !long_done_q;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Directed and randomized checks of button_reader against a run-length
// reference model of the debounce and hold rules.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse, click_pulse, long_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse)
  );

  // Reference model: pipeline of raw samples, accepted level, length of the
  // current run disagreeing with the accepted level, and settled hold time.
  bit m_s1 = 1'b1, m_s2 = 1'b1;
  bit m_pressed = 1'b0, m_long = 1'b0;
  int m_run = 0, m_hold = 0;
  bit e_press, e_rel, e_click, e_long;

  task automatic model_edge();
    bit seen;
    e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_long = 1'b0;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      seen = m_s2;
      if (!m_pressed) begin
        if (seen == 1'b0) begin
          m_run++;
          if (m_run == D + 1) begin
            m_pressed = 1'b1; e_press = 1'b1; m_run = 0; m_hold = 0; m_long = 1'b0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (seen == 1'b1) begin
          m_run++;
          if (m_run == D + 1) begin
            m_pressed = 1'b0; e_rel = 1'b1; e_click = !m_long; m_run = 0;
          end
        end else begin
          if (m_run == 0) begin
            if (m_hold < L) m_hold++;
            if (m_hold == L && !m_long) begin
              e_long = 1'b1; m_long = 1'b1;
            end
          end
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    btn_n = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("m_pressed", pressed, m_pressed);
    chk("m_press", press_pulse, e_press);
    chk("m_release", release_pulse, e_rel);
    chk("m_click", click_pulse, e_click);
    chk("m_long", long_pulse, e_long);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("rst_out", pressed | press_pulse | release_pulse | click_pulse | long_pulse, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit lvl;
    int run_len;

    // Power-on with the button released throughout
    do_reset();
    for (int e = 0; e < 100; e++) begin
      tick(1'b1);
      chk("idle_quiet", pressed | press_pulse | release_pulse | click_pulse | long_pulse, 1'b0);
    end

    // Clean press and release
    do_reset();
    for (int e = 0; e < 20; e++) begin
      tick(e < 8 ? 1'b0 : 1'b1);
      chk("clean_press", press_pulse, e == 6);
      chk("clean_release", release_pulse, e == 14);
      chk("clean_click", click_pulse, e == 14);
      chk("clean_level", pressed, e >= 6 && e < 14);
    end

    // Press bounce, then a 2-cycle release glitch while held
    do_reset();
    for (int e = 0; e < 30; e++) begin
      tick((e == 3 || e == 14 || e == 15 || e >= 20) ? 1'b1 : 1'b0);
      chk("bounce_press", press_pulse, e == 10);
      chk("bounce_release", release_pulse, e == 26);
      chk("bounce_click", click_pulse, e == 26);
      chk("bounce_long", long_pulse, 1'b0);
      chk("bounce_level", pressed, e >= 10 && e < 26);
    end

    // Long press
    do_reset();
    for (int e = 0; e < 36; e++) begin
      tick(e < 26 ? 1'b0 : 1'b1);
      chk("long_press", press_pulse, e == 6);
      chk("long_long", long_pulse, e == 16);
      chk("long_release", release_pulse, e == 32);
      chk("long_click", click_pulse, 1'b0);
    end

    // Release seen in the cycle the hold would reach the limit
    do_reset();
    for (int e = 0; e < 25; e++) begin
      tick(e < 14 ? 1'b0 : 1'b1);
      chk("race_long", long_pulse, 1'b0);
      chk("race_release", release_pulse, e == 20);
      chk("race_click", click_pulse, e == 20);
    end

    // Reset while held, button still down afterwards
    do_reset();
    for (int e = 0; e < 26; e++) begin
      rst_n = !(e == 10 || e == 11);
      tick(1'b0);
      chk("rst_press", press_pulse, e == 6 || e == 18);
      chk("rst_level", pressed, (e >= 6 && e < 10) || e >= 18);
      chk("rst_other", release_pulse | click_pulse | long_pulse, 1'b0);
    end
    rst_n = 1'b1;

    // Randomized bouncy runs with occasional resets
    do_reset();
    lvl = 1'b1;
    for (int r = 0; r < 120; r++) begin
      lvl = ~lvl;
      run_len = $urandom_range(1, 24);
      for (int i = 0; i < run_len; i++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        tick(lvl);
      end
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
